// File: rtl/ldpc_qc_product_decoder.sv
// ---------------------------------------------------------------------------
// ldpc_qc_product_decoder
//
// Single-iteration min-sum decoder for a quasi-cyclic product LDPC code made
// of a K x K array of L-word variable banks. Every variable sits on one row
// check (its bank row) and one column check (its bank column) at the same
// address. Three frames are in flight at once. While frame n is loaded into
// one half of the intrinsic ping-pong, frame n-1 is decoded from the other
// half. Its hard decisions go to one half of the output ping-pong while
// frame n-2 is read out of the other half.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset (control and outputs)
//   ext_reset      synchronous frame-sync pulse: restarts the frame counter
//                  and aborts a decode in progress
//   en             global enable; with en=0 nothing changes
//   pe_select      one-hot bank write select for the LLR being loaded
//   int_in         LLR sample (two's complement)
//   load_add_in    load address inside the selected bank(s)
//   read_add_in    address of the hard decisions to read out
//   column_select  per-column update enable for dec_out_fin
//   f_id           toggles at every frame boundary
//   relay          {decoding, decode address}; zero when idle
//   dec_out_fin    hard decisions [x][y] of all banks at read_add_in
// ---------------------------------------------------------------------------
module ldpc_qc_product_decoder #(
    parameter int L                    = 32,
    parameter int K                    = 6,
    parameter int ADDR_WIDTH           = 5,
    parameter int MESSAGE_WIDTH        = 5,
    parameter int CNU_DATA_IN_WIDTH    = 6,
    parameter int CNU_DATA_OUT_WIDTH   = 5,
    parameter int INTRINSIC_DATA_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ext_reset,
    input  logic                    en,
    input  logic [K*K-1:0]          pe_select,
    input  logic [MESSAGE_WIDTH-1:0] int_in,
    input  logic [ADDR_WIDTH-1:0]   load_add_in,
    input  logic [ADDR_WIDTH-1:0]   read_add_in,
    input  logic [K-1:0]            column_select,
    output logic                    f_id,
    output logic [5:0]              relay,
    output logic [K-1:0][K-1:0]     dec_out_fin
);

    localparam int NB        = K * K;
    localparam int FRAME_LEN = L * NB;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int W         = CNU_DATA_IN_WIDTH;
    localparam int IW        = INTRINSIC_DATA_WIDTH;
    localparam int OW        = CNU_DATA_OUT_WIDTH;
    localparam int MAG_W     = OW - 1;
    localparam int SUM_W     = W + 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
    localparam logic [W-1:0]          MAG_MAX   = W'((1 << MAG_W) - 1);

    // Magnitude of a sign-extended LLR, saturated so that the most negative
    // input (-16) maps onto the largest representable message magnitude.
    function automatic logic [MAG_W-1:0] sat_mag(input logic [W-1:0] v);
        logic [W-1:0] a;
        a = v[W-1] ? (~v + W'(1)) : v;
        if (a > MAG_MAX) a = MAG_MAX;
        return a[MAG_W-1:0];
    endfunction

    // Min-sum check message from the K-1 other members of a check.
    // A zero input counts as positive (its sign bit is clear).
    function automatic logic [OW-1:0] min_sum(input logic [(K-1)*W-1:0] others);
        logic             sgn;
        logic [MAG_W-1:0] mn;
        logic [MAG_W-1:0] m;
        sgn = 1'b0;
        mn  = '1;
        for (int i = 0; i < K - 1; i++) begin
            sgn = sgn ^ others[i*W + W - 1];
            m   = sat_mag(others[i*W +: W]);
            if (m < mn) mn = m;
        end
        return sgn ? (~{1'b0, mn} + OW'(1)) : {1'b0, mn};
    endfunction

    // Hard decision of variable (x,y): sign of intrinsic + row + column
    // message, evaluated wide enough that the sum cannot overflow.
    function automatic logic hard_decision(input logic [NB*W-1:0] llr,
                                           input int x, input int y);
        logic [(K-1)*W-1:0]      row_o;
        logic [(K-1)*W-1:0]      col_o;
        logic signed [W-1:0]     self_v;
        logic signed [OW-1:0]    r_msg;
        logic signed [OW-1:0]    c_msg;
        logic signed [SUM_W-1:0] sum;
        int n;
        row_o = '0;
        col_o = '0;
        n = 0;
        for (int j = 0; j < K; j++) begin
            if (j != y) begin
                row_o[n*W +: W] = llr[(x*K + j)*W +: W];
                n = n + 1;
            end
        end
        n = 0;
        for (int i = 0; i < K; i++) begin
            if (i != x) begin
                col_o[n*W +: W] = llr[(i*K + y)*W +: W];
                n = n + 1;
            end
        end
        self_v = llr[(x*K + y)*W +: W];
        r_msg  = min_sum(row_o);
        c_msg  = min_sum(col_o);
        sum = {{(SUM_W-W){self_v[W-1]}}, self_v}
            + {{(SUM_W-OW){r_msg[OW-1]}}, r_msg}
            + {{(SUM_W-OW){c_msg[OW-1]}}, c_msg};
        return sum[SUM_W-1];
    endfunction

    // Storage: intrinsic and hard-decision ping-pongs. The loader and the
    // decoder's output side use half pp; the decoder's input side and the
    // reader use the other half.
    logic [IW-1:0]   intr_mem [2][NB][L];
    logic [NB-1:0]   hard_mem [2][L];

    logic [CNT_W-1:0]      frame_cnt;
    logic                  pp;
    logic                  dec_busy;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  f_id_r;

    logic                  rd_half;
    logic [NB*W-1:0]       llr_flat;
    logic [NB-1:0]         hard_bits;
    logic [NB-1:0]         rd_word;

    assign rd_half = ~pp;
    assign f_id    = f_id_r;
    assign relay   = {dec_busy, dec_addr};
    assign rd_word = hard_mem[rd_half][read_add_in];

    // Decode stage: all banks at the current decode address, sign-extended.
    always_comb begin
        llr_flat = '0;
        for (int b = 0; b < NB; b++) begin
            llr_flat[b*W +: W] = {{(W-IW){intr_mem[rd_half][b][dec_addr][IW-1]}},
                                  intr_mem[rd_half][b][dec_addr]};
        end
    end

    always_comb begin
        hard_bits = '0;
        for (int x = 0; x < K; x++) begin
            for (int y = 0; y < K; y++) begin
                hard_bits[x*K + y] = hard_decision(llr_flat, x, y);
            end
        end
    end

    // Memory writes: loads follow en only; decoder writes stop on an abort.
    always_ff @(posedge clk) begin
        if (en && !reset) begin
            for (int b = 0; b < NB; b++) begin
                if (pe_select[b]) intr_mem[pp][b][load_add_in] <= IW'(int_in);
            end
        end
        if (en && dec_busy && !reset && !ext_reset) begin
            hard_mem[pp][dec_addr] <= hard_bits;
        end
    end

    // Frame sequencing, decode address walk and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            pp          <= 1'b0;
            f_id_r      <= 1'b0;
            dec_busy    <= 1'b0;
            dec_addr    <= '0;
            dec_out_fin <= '0;
        end else begin
            if (ext_reset) begin
                frame_cnt <= '0;
                dec_busy  <= 1'b0;
                dec_addr  <= '0;
            end else if (en) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    f_id_r    <= ~f_id_r;
                    pp        <= ~pp;
                    dec_busy  <= 1'b1;
                    dec_addr  <= '0;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                    if (dec_busy) begin
                        if (dec_addr == ADDR_LAST) begin
                            dec_busy <= 1'b0;
                            dec_addr <= '0;
                        end else begin
                            dec_addr <= dec_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            if (en) begin
                for (int y = 0; y < K; y++) begin
                    if (column_select[y]) begin
                        for (int x = 0; x < K; x++) begin
                            dec_out_fin[x][y] <= rd_word[x*K + y];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_qc_product_decoder.sv
// ---------------------------------------------------------------------------
// tb_ldpc_qc_product_decoder
//
// Streams ten frames through the decoder, one LLR per cycle (one bank word
// per cycle fills exactly one frame period), and reads each decoded frame
// back two periods later. Expected hard decisions come from a plain integer
// min-sum model of the code. Also covers reset values, the frame period,
// relay sequencing, column gating, an enable hold and a frame-sync abort.
// ---------------------------------------------------------------------------
module tb_ldpc_qc_product_decoder;

    localparam int L  = 32;
    localparam int K  = 6;
    localparam int NB = K * K;
    localparam int FL = L * NB;
    localparam int NF = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ext_reset;
    logic                 en;
    logic [NB-1:0]        pe_select;
    logic [4:0]           int_in;
    logic [4:0]           load_add_in;
    logic [4:0]           read_add_in;
    logic [K-1:0]         column_select;
    logic                 f_id;
    logic [5:0]           relay;
    logic [K-1:0][K-1:0]  dec_out_fin;

    always #5 clk = ~clk;

    ldpc_qc_product_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .ext_reset     (ext_reset),
        .en            (en),
        .pe_select     (pe_select),
        .int_in        (int_in),
        .load_add_in   (load_add_in),
        .read_add_in   (read_add_in),
        .column_select (column_select),
        .f_id          (f_id),
        .relay         (relay),
        .dec_out_fin   (dec_out_fin)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int                  frames  [NF][NB][L];
    logic                hard_ref[NF][NB][L];
    logic [K-1:0][K-1:0] exp_dec;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_ref(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > 15) ? 15 : m;
    endfunction

    // Plain min-sum over the row and column of every variable.
    task automatic build_ref(input int f);
        int rneg, rmin, cneg, cmin, v, rmsg, cmsg;
        for (int a = 0; a < L; a++) begin
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++) begin
                    rneg = 0; rmin = 15; cneg = 0; cmin = 15;
                    for (int j = 0; j < K; j++) begin
                        if (j != y) begin
                            v = frames[f][x*K + j][a];
                            if (v < 0) rneg = 1 - rneg;
                            if (sat_ref(v) < rmin) rmin = sat_ref(v);
                        end
                        if (j != x) begin
                            v = frames[f][j*K + y][a];
                            if (v < 0) cneg = 1 - cneg;
                            if (sat_ref(v) < cmin) cmin = sat_ref(v);
                        end
                    end
                    rmsg = rneg ? -rmin : rmin;
                    cmsg = cneg ? -cmin : cmin;
                    hard_ref[f][x*K + y][a] = ((frames[f][x*K + y][a] + rmsg + cmsg) < 0);
                end
            end
        end
    endtask

    task automatic fill_frame(input int f, input int kind);
        int ext_vals[6];
        ext_vals = '{-16, -15, -1, 0, 1, 15};
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < L; a++) begin
                case (kind)
                    0: frames[f][b][a] = 5;
                    1, 2: frames[f][b][a] = 7;
                    4: frames[f][b][a] = ext_vals[$urandom_range(0, 5)];
                    default: frames[f][b][a] = int'($urandom_range(0, 31)) - 16;
                endcase
            end
        end
        if (kind == 1) frames[f][2*K + 3][9] = -3;
        if (kind == 2) begin
            frames[f][2*K + 3][9] = -16;
            frames[f][2*K + 4][9] = -16;
        end
    endtask

    function automatic logic [5:0] relay_exp(input int k, input int i);
        if (i == FL - 1) return 6'b100000;
        if (k >= 1 && i <= L - 2) return {1'b1, 5'(i + 1)};
        return 6'd0;
    endfunction

    // en low for 10 cycles while decoding; loads and reads offered meanwhile
    // must have no effect.
    task automatic hold_test(input int k);
        en            = 1'b0;
        pe_select     = '1;
        int_in        = 5'b10000;
        load_add_in   = 5'd3;
        read_add_in   = 5'd7;
        column_select = '1;
        for (int h = 0; h < 10; h++) begin
            tick();
            chk($sformatf("hold_relay h%0d", h), relay, 6'b101010);
            chk($sformatf("hold_f_id h%0d", h), f_id, 64'(k & 1));
            chk($sformatf("hold_dec h%0d", h), dec_out_fin, exp_dec);
        end
        en = 1'b1;
    endtask

    initial begin
        logic [K-1:0] cs;
        int b, a;
        bit reading;

        reset = 1'b1; ext_reset = 1'b0; en = 1'b0;
        pe_select = '0; int_in = '0; load_add_in = '0;
        read_add_in = '0; column_select = '0;

        fill_frame(0, 0);
        fill_frame(1, 1);
        fill_frame(2, 2);
        fill_frame(3, 3);
        fill_frame(4, 4);
        for (int f = 5; f < NF; f++) fill_frame(f, 3);
        for (int f = 0; f < NF; f++) build_ref(f);
        exp_dec = '0;

        tick();
        tick();
        chk("rst_f_id", f_id, 0);
        chk("rst_relay", relay, 0);
        chk("rst_dec", dec_out_fin, 0);

        reset = 1'b0;
        ext_reset = 1'b1;
        tick();
        ext_reset = 1'b0;
        en = 1'b1;

        for (int k = 0; k < NF; k++) begin
            if (k == 5)      cs = 6'b000001;
            else if (k == 6) cs = 6'($urandom_range(1, 62));
            else             cs = 6'b111111;
            for (int i = 0; i < FL; i++) begin
                if (k == 7 && i == 10) hold_test(k);
                b = i / L;
                a = i % L;
                pe_select   = NB'(1) << b;
                int_in      = frames[k][b][a][4:0];
                load_add_in = 5'(a);
                reading     = (k >= 2 && i < L);
                read_add_in = 5'(a);
                column_select = reading ? cs : 6'b000000;
                tick();
                if (reading) begin
                    for (int y = 0; y < K; y++) begin
                        if (cs[y]) begin
                            for (int x = 0; x < K; x++) exp_dec[x][y] = hard_ref[k-2][x*K + y][i];
                        end
                    end
                end
                if (reading || i == L)
                    chk($sformatf("dec k%0d i%0d", k, i), dec_out_fin, exp_dec);
                if (k == 4 && i == 9) begin
                    chk("weak_err_bit23", dec_out_fin[2][3], 1);
                    chk("weak_err_bit00", dec_out_fin[0][0], 0);
                end
                if (i < 40 || i == FL - 1)
                    chk($sformatf("relay k%0d i%0d", k, i), relay, relay_exp(k, i));
                if (i == FL - 2)
                    chk($sformatf("f_id_pre k%0d", k), f_id, 64'(k & 1));
                if (i == FL - 1)
                    chk($sformatf("f_id_tog k%0d", k), f_id, 64'((k + 1) & 1));
            end
        end

        // Frame-sync abort during a decode.
        pe_select = '0;
        column_select = '0;
        tick();
        chk("xrst_pre_relay", relay, 6'b100001);
        ext_reset = 1'b1;
        tick();
        ext_reset = 1'b0;
        chk("xrst_relay", relay, 0);
        chk("xrst_f_id", f_id, 0);
        for (int i = 0; i < FL; i++) begin
            tick();
            if (i < 40) chk($sformatf("xrst_idle i%0d", i), relay, 0);
            if (i == FL - 2) chk("xrst_f_id_pre", f_id, 0);
            if (i == FL - 1) begin
                chk("xrst_f_id_tog", f_id, 1);
                chk("xrst_relay_start", relay, 6'b100000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
